// File: rtl/lcd_watch_rtc_ampm_if.sv
// Interface bundling the watch core control inputs and display outputs.
// The master side drives run/mode/load controls; the slave side is the core.
interface lcd_watch_rtc_ampm_if;
   logic       RUN;
   logic       MODE_KEY;
   logic       LOAD;
   logic [4:0] SET_HOUR;
   logic [5:0] SET_MIN;
   logic [5:0] SET_SEC;
   logic [3:0] HOUR10;
   logic [3:0] HOUR1;
   logic [3:0] MIN10;
   logic [3:0] MIN1;
   logic [3:0] SEC10;
   logic [3:0] SEC1;
   logic       PM;
   logic       MODE24;
   logic       SEC_TICK;

   modport master (
      output RUN, MODE_KEY, LOAD, SET_HOUR, SET_MIN, SET_SEC,
      input  HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1, PM, MODE24, SEC_TICK
   );

   modport slave (
      input  RUN, MODE_KEY, LOAD, SET_HOUR, SET_MIN, SET_SEC,
      output HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1, PM, MODE24, SEC_TICK
   );
endinterface

// File: rtl/lcd_watch_rtc_ampm.sv
// Time-of-day core for the LCD watch: prescaled sec/min/hour counters with
// synchronous load, key-toggled 12/24-hour format and registered BCD display.
module lcd_watch_rtc_ampm #(
   parameter int unsigned TICK_DIV   = 1000,
   parameter bit          MODE24_RST = 1'b0,
   parameter bit          ZERO_AS_12 = 1'b1
) (
   input logic                   CLK,
   input logic                   RESETN,
   lcd_watch_rtc_ampm_if.slave   bus
);

   localparam logic [15:0] TERM = 16'(TICK_DIV - 1);
   // Hour digits shown out of reset: internal hour 0 in the reset format.
   localparam logic [7:0]  RST_HOUR_BCD = (!MODE24_RST && ZERO_AS_12) ? 8'h12 : 8'h00;

   logic [15:0] presc_q, presc_d;
   logic [5:0]  sec_q, sec_d;
   logic [5:0]  min_q, min_d;
   logic [4:0]  hour_q, hour_d;
   logic        mode24_q, mode24_d;
   logic        key_q;
   logic        sec_tick_q, sec_tick_d;
   logic [7:0]  hour_bcd_q, hour_bcd_d;
   logic [7:0]  min_bcd_q, min_bcd_d;
   logic [7:0]  sec_bcd_q, sec_bcd_d;
   logic        pm_q, pm_d;
   logic        tick;

   // Hour value to display in the selected format.
   function automatic logic [4:0] disp_hour(input logic [4:0] h, input logic m24);
      if (m24)
         return h;
      if (h == 5'd0)
         return ZERO_AS_12 ? 5'd12 : 5'd0;
      if (h > 5'd12)
         return h - 5'd12;
      return h;
   endfunction

   // Binary 0..59 to packed {tens, ones} BCD.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [3:0] t;
      if (v >= 6'd50)      t = 4'd5;
      else if (v >= 6'd40) t = 4'd4;
      else if (v >= 6'd30) t = 4'd3;
      else if (v >= 6'd20) t = 4'd2;
      else if (v >= 6'd10) t = 4'd1;
      else                 t = 4'd0;
      return {t, 4'(v - 6'd10 * {2'b00, t})};
   endfunction

   // Prescaler, time counters, load and mode-key next state.
   always_comb begin
      tick       = bus.RUN && (presc_q == TERM);
      presc_d    = presc_q;
      sec_d      = sec_q;
      min_d      = min_q;
      hour_d     = hour_q;
      sec_tick_d = tick && !bus.LOAD;
      mode24_d   = mode24_q ^ (bus.MODE_KEY && !key_q);

      if (bus.LOAD) begin
         presc_d = '0;
         if (bus.SET_SEC  <= 6'd59) sec_d  = bus.SET_SEC;
         if (bus.SET_MIN  <= 6'd59) min_d  = bus.SET_MIN;
         if (bus.SET_HOUR <= 5'd23) hour_d = bus.SET_HOUR;
      end else begin
         if (bus.RUN)
            presc_d = tick ? '0 : presc_q + 16'd1;
         if (tick) begin
            if (sec_q == 6'd59) begin
               sec_d = '0;
               if (min_q == 6'd59) begin
                  min_d  = '0;
                  hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end
      end
   end

   // Display conversion from the current counters and format.
   always_comb begin
      hour_bcd_d = to_bcd({1'b0, disp_hour(hour_q, mode24_q)});
      min_bcd_d  = to_bcd(min_q);
      sec_bcd_d  = to_bcd(sec_q);
      pm_d       = (hour_q >= 5'd12);
   end

   // State and display registers.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         presc_q    <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         hour_q     <= '0;
         mode24_q   <= MODE24_RST;
         key_q      <= 1'b0;
         sec_tick_q <= 1'b0;
         hour_bcd_q <= RST_HOUR_BCD;
         min_bcd_q  <= '0;
         sec_bcd_q  <= '0;
         pm_q       <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         mode24_q   <= mode24_d;
         key_q      <= bus.MODE_KEY;
         sec_tick_q <= sec_tick_d;
         hour_bcd_q <= hour_bcd_d;
         min_bcd_q  <= min_bcd_d;
         sec_bcd_q  <= sec_bcd_d;
         pm_q       <= pm_d;
      end
   end

   assign bus.HOUR10   = hour_bcd_q[7:4];
   assign bus.HOUR1    = hour_bcd_q[3:0];
   assign bus.MIN10    = min_bcd_q[7:4];
   assign bus.MIN1     = min_bcd_q[3:0];
   assign bus.SEC10    = sec_bcd_q[7:4];
   assign bus.SEC1     = sec_bcd_q[3:0];
   assign bus.PM       = pm_q;
   assign bus.MODE24   = mode24_q;
   assign bus.SEC_TICK = sec_tick_q;

endmodule

// File: tb/tb_lcd_watch_rtc_ampm.sv
// Directed bench for the LCD watch time-of-day core.
module tb_lcd_watch_rtc_ampm;

   logic CLK = 1'b0;
   logic RESETN;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 CLK = ~CLK;

   lcd_watch_rtc_ampm_if ifa ();
   lcd_watch_rtc_ampm_if ifb ();

   // Second instance mirrors the stimulus, differing only in the hour-0 rendering.
   assign ifb.RUN      = ifa.RUN;
   assign ifb.MODE_KEY = ifa.MODE_KEY;
   assign ifb.LOAD     = ifa.LOAD;
   assign ifb.SET_HOUR = ifa.SET_HOUR;
   assign ifb.SET_MIN  = ifa.SET_MIN;
   assign ifb.SET_SEC  = ifa.SET_SEC;

   lcd_watch_rtc_ampm #(.TICK_DIV(4), .MODE24_RST(1'b0), .ZERO_AS_12(1'b1)) dut_a (
      .CLK(CLK), .RESETN(RESETN), .bus(ifa)
   );

   lcd_watch_rtc_ampm #(.TICK_DIV(4), .MODE24_RST(1'b0), .ZERO_AS_12(1'b0)) dut_b (
      .CLK(CLK), .RESETN(RESETN), .bus(ifb)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   function automatic logic [31:0] disp_a();
      return {8'h00, ifa.HOUR10, ifa.HOUR1, ifa.MIN10, ifa.MIN1, ifa.SEC10, ifa.SEC1};
   endfunction

   function automatic logic [31:0] hour_a();
      return {24'h0, ifa.HOUR10, ifa.HOUR1};
   endfunction

   function automatic logic [31:0] hour_b();
      return {24'h0, ifb.HOUR10, ifb.HOUR1};
   endfunction

   task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      ifa.SET_HOUR = h;
      ifa.SET_MIN  = m;
      ifa.SET_SEC  = s;
      ifa.LOAD     = 1'b1;
      step(1);
      ifa.LOAD     = 1'b0;
   endtask

   task automatic key_pulse();
      ifa.MODE_KEY = 1'b1;
      step(1);
      ifa.MODE_KEY = 1'b0;
      step(1);
   endtask

   initial begin
      int ticks;
      int toggles;
      logic prev_mode;
      logic [4:0] hrs  [7] = '{5'd0, 5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd23};
      logic [7:0] exph [7] = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h08, 8'h09, 8'h11};
      logic       expm [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      RESETN       = 1'b0;
      ifa.RUN      = 1'b1;
      ifa.MODE_KEY = 1'b0;
      ifa.LOAD     = 1'b0;
      ifa.SET_HOUR = '0;
      ifa.SET_MIN  = '0;
      ifa.SET_SEC  = '0;
      step(2);

      // Reset values
      chk("rst_disp", disp_a(), 32'h120000);
      chk("rst_pm", 32'(ifa.PM), 32'd0);
      chk("rst_mode", 32'(ifa.MODE24), 32'd0);
      chk("rst_tick", 32'(ifa.SEC_TICK), 32'd0);
      chk("rst_hour_z0", hour_b(), 32'h00);

      // First tick four edges after release
      RESETN = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step(1);
         chk("first_tick_early", 32'(ifa.SEC_TICK), 32'd0);
      end
      step(1);
      chk("first_tick", 32'(ifa.SEC_TICK), 32'd1);
      step(1);
      chk("first_tick_one_cycle", 32'(ifa.SEC_TICK), 32'd0);
      chk("first_sec_disp", disp_a(), 32'h120001);

      // 24-hour rollover
      key_pulse();
      chk("mode_to_24", 32'(ifa.MODE24), 32'd1);
      load(5'd23, 6'd59, 6'd58);
      ticks = 0;
      for (int i = 1; i <= 9; i++) begin
         step(1);
         if (ifa.SEC_TICK) ticks++;
         if (i == 1) chk("roll_load", disp_a(), 32'h235958);
         if (i == 5) begin
            chk("roll_59", disp_a(), 32'h235959);
            chk("roll_pm1", 32'(ifa.PM), 32'd1);
         end
         if (i == 9) begin
            chk("roll_00", disp_a(), 32'h000000);
            chk("roll_pm0", 32'(ifa.PM), 32'd0);
         end
      end
      chk("roll_tick_count", 32'(ticks), 32'd2);
      ifa.RUN = 1'b0;

      // 12-hour mapping
      key_pulse();
      chk("mode_to_12", 32'(ifa.MODE24), 32'd0);
      for (int i = 0; i < 7; i++) begin
         load(hrs[i], 6'd0, 6'd0);
         step(1);
         chk($sformatf("h12_%0d", hrs[i]), hour_a(), 32'(exph[i]));
         chk($sformatf("pm_%0d", hrs[i]), 32'(ifa.PM), 32'(expm[i]));
         if (hrs[i] == 5'd0)
            chk("h12_zero_as_00", hour_b(), 32'h00);
      end

      // LOAD coincident with terminal count
      load(5'd1, 6'd0, 6'd0);
      ifa.RUN = 1'b1;
      step(3);
      load(5'd10, 6'd20, 6'd30);
      chk("coinc_tick_dropped", 32'(ifa.SEC_TICK), 32'd0);
      step(1);
      chk("coinc_disp", disp_a(), 32'h102030);
      step(2);
      chk("coinc_tick_early", 32'(ifa.SEC_TICK), 32'd0);
      step(1);
      chk("coinc_tick", 32'(ifa.SEC_TICK), 32'd1);
      step(1);
      chk("coinc_next", disp_a(), 32'h102031);
      ifa.RUN = 1'b0;

      // Out-of-range fields are ignored individually
      load(5'd5, 6'd6, 6'd7);
      load(5'd25, 6'd70, 6'd15);
      step(1);
      chk("range_partial", disp_a(), 32'h050615);

      // Held key gives one toggle
      load(5'd14, 6'd0, 6'd0);
      step(1);
      chk("key_pre_disp", hour_a(), 32'h02);
      chk("key_pre_pm", 32'(ifa.PM), 32'd1);
      toggles = 0;
      prev_mode = ifa.MODE24;
      ifa.MODE_KEY = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step(1);
         if (ifa.MODE24 != prev_mode) toggles++;
         prev_mode = ifa.MODE24;
         if (i == 1) begin
            chk("key_toggle", 32'(ifa.MODE24), 32'd1);
            chk("key_disp_latency", hour_a(), 32'h02);
         end
         if (i == 2) chk("key_disp_24", hour_a(), 32'h14);
      end
      chk("key_toggle_count", 32'(toggles), 32'd1);
      chk("key_counters", disp_a(), 32'h140000);
      ifa.MODE_KEY = 1'b0;
      step(1);

      // Asynchronous reset mid-second
      load(5'd7, 6'd30, 6'd45);
      ifa.RUN = 1'b1;
      step(2);
      chk("pre_areset", disp_a(), 32'h073045);
      #2;
      RESETN = 1'b0;
      #1;
      chk("areset_disp", disp_a(), 32'h120000);
      chk("areset_pm", 32'(ifa.PM), 32'd0);
      chk("areset_mode", 32'(ifa.MODE24), 32'd0);
      chk("areset_tick", 32'(ifa.SEC_TICK), 32'd0);
      step(1);
      RESETN = 1'b1;
      step(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
